// File: rtl/data_memory_responder.sv
// Word-addressed data memory responder with a ready/error handshake and a fixed access latency.
// A request is captured on acceptance and is answered by a one-cycle ready pulse LATENCY cycles later.
module data_memory_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] readData,
  output logic        ready,
  output logic        error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  count, count_next;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  op_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_op;
  logic        req_err;
  logic        commit;
  logic [AW-1:0] req_idx;

  // With LATENCY=1 the acceptance edge is also the commit edge, so the live inputs are used there.
  always_comb begin
    req_addr  = (state == IDLE) ? address : addr_q;
    req_wdata = (state == IDLE) ? writeData : wdata_q;
    req_op    = (state == IDLE) ? {memRead, memWrite} : op_q;
    req_err   = (&req_op) || (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH));
    req_idx   = req_addr[AW+1:2];
  end

  always_comb begin
    state_next = state;
    count_next = count;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (memRead || memWrite) begin
          if (LATENCY == 1) begin
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
            count_next = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        count_next = count - 4'd1;
        if (count <= 4'd1) begin
          state_next = RESP;
          count_next = 4'd0;
          commit     = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      op_q     <= 2'b00;
      err_q    <= 1'b0;
      readData <= 32'd0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (state == IDLE && (memRead || memWrite)) begin
        addr_q  <= address;
        wdata_q <= writeData;
        op_q    <= {memRead, memWrite};
      end
      if (commit) begin
        err_q <= req_err;
        if (!req_err && req_op == 2'b10)
          readData <= mem[req_idx];
      end
    end
  end

  // Contents must clear on reset, so the array is built from resettable flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 32'd0;
    end else if (commit && !req_err && req_op == 2'b01) begin
      mem[req_idx] <= req_wdata;
    end
  end

  assign ready = (state == RESP);
  assign error = ready && err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: vector table through a scoreboard,
// plus hand sequences for input isolation, reset abort and the latency sweep.
module tb_data_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] address, writeData, readData;
  logic        memRead, memWrite, ready, error;

  logic        s_read;
  logic [31:0] s_addr;
  logic [31:0] rd1, rd5;
  logic        rdy1, rdy5, err1, err5;

  data_memory_responder #(.DEPTH(64), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .memRead(memRead), .memWrite(memWrite),
    .readData(readData), .ready(ready), .error(error));

  data_memory_responder #(.DEPTH(64), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .address(s_addr), .writeData(32'd0),
    .memRead(s_read), .memWrite(1'b0),
    .readData(rd1), .ready(rdy1), .error(err1));

  data_memory_responder #(.DEPTH(64), .LATENCY(5)) dut_l5 (
    .clk(clk), .rst(rst), .address(s_addr), .writeData(32'd0),
    .memRead(s_read), .memWrite(1'b0),
    .readData(rd5), .ready(rdy5), .error(err5));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];
  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drives one request for a single cycle, then waits (bounded) for the ready pulse.
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_err, input logic [31:0] exp_rd, input bit disturb);
    exp_t e;
    int   k;
    bit   seen;
    @(negedge clk);
    memRead = rd; memWrite = wr; address = a; writeData = d;
    e.err = exp_err; e.rdata = exp_rd;
    sb.push_back(e);
    @(negedge clk);
    memRead = 1'b0; memWrite = 1'b0;
    if (disturb) begin
      address = 32'hC; memWrite = 1'b1; writeData = 32'hFFFF_FFFF;
    end
    k = 1; seen = 1'b0;
    while (k <= 20 && !seen) begin
      if (ready) seen = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    memRead = 1'b0; memWrite = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout actual=no_ready required=ready", name);
    end else begin
      check32({name, " latency"}, 32'(k), 32'd2);
      check32({name, " error"}, {31'd0, error}, {31'd0, e.err});
      check32({name, " readData"}, readData, e.rdata);
      @(negedge clk);
      check32({name, " pulse_end"}, {31'd0, ready}, 32'd0);
      if (disturb) begin
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          check32({name, " no_second"}, {31'd0, ready}, 32'd0);
        end
      end
    end
    $display("txn %s rd=%0b wr=%0b addr=%h -> readData=%h error=%0b", name, rd, wr, a, readData, error);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=hung required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int last1, last5, n1, n5, pulses;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,           1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_00FC, 32'h0,           1'b0, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0004, 32'hDEAD_BEEF,   1'b0, 32'h0000_0000};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,           1'b0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0008, 32'hA5A5_0002,   1'b0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_000C, 32'h3333_3333,   1'b0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,           1'b0, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0002, 32'h0,           1'b1, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,           1'b1, 32'hDEAD_BEEF};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0004, 32'h0,           1'b1, 32'hDEAD_BEEF};
    vecs[10] = '{1'b0, 1'b1, 32'h0000_0101, 32'h1111_1111,   1'b1, 32'hDEAD_BEEF};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,           1'b0, 32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0100, 32'h5555_5555,   1'b1, 32'hDEAD_BEEF};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,           1'b0, 32'h0000_0000};

    rst = 1'b0; memRead = 1'b0; memWrite = 1'b0; address = 32'd0; writeData = 32'd0;
    s_read = 1'b0; s_addr = 32'd0;
    repeat (2) @(negedge clk);
    check32("reset ready", {31'd0, ready}, 32'd0);
    check32("reset error", {31'd0, error}, 32'd0);
    check32("reset readData", readData, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++)
      access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
             vecs[i].err, vecs[i].rdata, 1'b0);

    // Input changes during WAIT must be ignored and must not create a second request.
    access("isolate_load8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'hA5A5_0002, 1'b1);
    access("isolate_checkC", 1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 32'h3333_3333, 1'b0);
    access("reload4", 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0);

    // Reset during WAIT aborts the store and clears memory.
    @(negedge clk);
    memWrite = 1'b1; address = 32'h10; writeData = 32'h1234_5678;
    @(negedge clk);
    memWrite = 1'b0;
    #2 rst = 1'b0;
    #1;
    check32("abort ready_in_reset", {31'd0, ready}, 32'd0);
    check32("abort readData_async", readData, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check32("abort no_ready", 32'(pulses), 32'd0);
    $display("txn abort_store addr=00000010 ready_pulses=%0d", pulses);
    access("abort_load10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 1'b0);
    access("abort_load4", 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0);

    // Strobe held high continuously: one pulse every LATENCY+1 cycles.
    @(negedge clk);
    s_read = 1'b1; s_addr = 32'h0;
    last1 = -1; last5 = -1; n1 = 0; n5 = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (rdy1) begin
        if (last1 >= 0) check32("sweep_l1 period", 32'(c - last1), 32'd2);
        check32("sweep_l1 error", {31'd0, err1}, 32'd0);
        last1 = c; n1++;
      end
      if (rdy5) begin
        if (last5 >= 0) check32("sweep_l5 period", 32'(c - last5), 32'd6);
        check32("sweep_l5 error", {31'd0, err5}, 32'd0);
        last5 = c; n5++;
      end
    end
    s_read = 1'b0;
    check32("sweep_l1 pulses", 32'(n1), 32'd30);
    check32("sweep_l5 pulses", 32'(n5), 32'd10);
    $display("txn sweep l1_pulses=%0d l5_pulses=%0d", n1, n5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
